// File: rtl/dma_reg_pkg.sv
// Shared register map, field positions, count width and engine state encoding for the DMA register block.
// Pure definitions: no latency, no flow control.
package dma_reg_pkg;
  localparam int CNT_W = 16;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_IO     = 8'h04;
  localparam logic [7:0] ADDR_MEM    = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_XFER   = 8'h10;
  localparam logic [7:0] ADDR_INTR   = 8'h14;
  localparam logic [7:0] ADDR_ERR    = 8'h18;

  localparam int CTRL_START    = 0;
  localparam int CTRL_WCNT_LSB = 1;
  localparam int CTRL_IO_MEM   = 17;
  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_REM_LSB  = 16;
  localparam int INTR_DONE     = 0;
  localparam int INTR_MASK     = 16;
  localparam int ERR_ADDR      = 0;
  localparam int ERR_ZERO      = 1;
  localparam int ERR_BUSY      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } eng_state_t;
endpackage

// File: rtl/dma_xfer_engine.sv
// Transfer engine: IDLE -> RUN for count cycles -> one DONE cycle, plus completed-transfer counter.
// Start takes effect on the write edge; starts outside IDLE or with zero count are dropped and flagged.
module dma_xfer_engine
  import dma_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done_evt,
  output logic             err_zero,
  output logic             err_busy,
  output logic [CNT_W-1:0] remaining,
  output logic [31:0]      xfer_cnt
);
  eng_state_t state, state_nxt;
  logic       go;

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      ST_IDLE: if (start && count != '0) begin
        go        = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN:  if (remaining == CNT_W'(1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state == ST_RUN);
  assign done_evt = (state == ST_DONE);
  // Both flags may fire together for a zero-count start while busy.
  assign err_zero = start && (count == '0);
  assign err_busy = start && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      xfer_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (go) remaining <= count;
      else if (busy) remaining <= remaining - CNT_W'(1);
      if (done_evt) xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/dma_reg_resp.sv
// DMA register responder: decode, registered rdata (1 cycle after rd_en, held otherwise), level irq.
// No backpressure; ERR register and its detection exist only when DMA_REG_ERR_EN is defined.
module dma_reg_resp
  import dma_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        busy
);
  logic [CNT_W-1:0] w_count;
  logic             io_mem;
  logic [31:0]      io_addr, mem_addr;
  logic             done_st, done_mask;
  logic             done_evt, eng_err_zero, eng_err_busy;
  logic [CNT_W-1:0] remaining;
  logic [31:0]      xfer_cnt;
  logic             in_page, mapped;
  logic [31:0]      rd_val;
  logic             wr_ok;
`ifdef DMA_REG_ERR_EN
  logic [2:0]       err, err_set, err_clr;
`endif

  assign in_page = (addr[31:8] == '0) && (addr[1:0] == 2'b00);
  assign wr_ok   = wr_en && mapped;

  always_comb begin
    mapped = 1'b0;
    rd_val = '0;
    if (in_page) begin
      case (addr[7:0])
        ADDR_CTRL: begin
          mapped = 1'b1;
          rd_val[CTRL_WCNT_LSB +: CNT_W] = w_count;
          rd_val[CTRL_IO_MEM]            = io_mem;
        end
        ADDR_IO:  begin mapped = 1'b1; rd_val = io_addr;  end
        ADDR_MEM: begin mapped = 1'b1; rd_val = mem_addr; end
        ADDR_STATUS: begin
          mapped = 1'b1;
          rd_val[STAT_BUSY]             = busy;
          rd_val[STAT_DONE]             = done_st;
          rd_val[STAT_REM_LSB +: CNT_W] = remaining;
        end
        ADDR_XFER: begin mapped = 1'b1; rd_val = xfer_cnt; end
        ADDR_INTR: begin
          mapped = 1'b1;
          rd_val[INTR_DONE] = done_st;
          rd_val[INTR_MASK] = done_mask;
        end
`ifdef DMA_REG_ERR_EN
        ADDR_ERR: begin mapped = 1'b1; rd_val[2:0] = err; end
`endif
        default: ;
      endcase
    end
  end

  dma_xfer_engine u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wr_ok && addr[7:0] == ADDR_CTRL && wdata[CTRL_START]),
    .count     (wdata[CTRL_WCNT_LSB +: CNT_W]),
    .busy      (busy),
    .done_evt  (done_evt),
    .err_zero  (eng_err_zero),
    .err_busy  (eng_err_busy),
    .remaining (remaining),
    .xfer_cnt  (xfer_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_count   <= '0;
      io_mem    <= 1'b0;
      io_addr   <= '0;
      mem_addr  <= '0;
      done_st   <= 1'b0;
      done_mask <= 1'b0;
      rdata     <= '0;
    end else begin
      // rdata samples pre-write state, so a same-address read+write returns the old value.
      if (rd_en) rdata <= rd_val;
      if (wr_ok && addr[7:0] == ADDR_CTRL) begin
        w_count <= wdata[CTRL_WCNT_LSB +: CNT_W];
        io_mem  <= wdata[CTRL_IO_MEM];
      end
      if (wr_ok && addr[7:0] == ADDR_IO)   io_addr  <= wdata;
      if (wr_ok && addr[7:0] == ADDR_MEM)  mem_addr <= wdata;
      if (wr_ok && addr[7:0] == ADDR_INTR) done_mask <= wdata[INTR_MASK];
      done_st <= (done_st & ~(wr_ok && addr[7:0] == ADDR_INTR && wdata[INTR_DONE])) | done_evt;
    end
  end

  assign irq = done_st & done_mask;

`ifdef DMA_REG_ERR_EN
  always_comb begin
    err_set           = '0;
    err_set[ERR_ADDR] = (wr_en || rd_en) && !mapped;
    err_set[ERR_ZERO] = eng_err_zero;
    err_set[ERR_BUSY] = eng_err_busy;
  end
  assign err_clr = (wr_ok && addr[7:0] == ADDR_ERR) ? wdata[2:0] : 3'b000;

  always_ff @(posedge clk) begin
    if (!rst_n) err <= '0;
    else        err <= (err & ~err_clr) | err_set;
  end
`else
  logic unused_err;
  assign unused_err = eng_err_zero ^ eng_err_busy;
`endif
endmodule

// File: tb/tb_dma_reg_resp.sv
// Bench for dma_reg_resp: directed scenarios then random traffic, every cycle compared to a register-map model.
module tb_dma_reg_resp;
  logic        clk = 1'b0;
  logic        rst_n, wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic        irq, busy;

  always #5 clk = ~clk;

  dma_reg_resp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq),
    .busy  (busy)
  );

`ifdef DMA_REG_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: transfer progress is tracked as "cycles of busy left" plus a done flag.
  logic [15:0] m_wcount;
  bit          m_io_mem, m_done_st, m_mask, m_done_phase;
  logic [31:0] m_io_addr, m_mem_addr, m_xfer, m_rdata;
  bit   [2:0]  m_err;
  int          m_run_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_mapped(input logic [31:0] a);
    if (a[31:8] != 24'd0 || a[1:0] != 2'd0) return 1'b0;
    case (a[7:0])
      8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14: return 1'b1;
      8'h18: return ERR_EN;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_mapped(a)) return 32'd0;
    case (a[7:0])
      8'h00: return {14'd0, m_io_mem, m_wcount, 1'b0};
      8'h04: return m_io_addr;
      8'h08: return m_mem_addr;
      8'h0C: return {16'(m_run_left), 14'd0, m_done_st, (m_run_left > 0)};
      8'h10: return m_xfer;
      8'h14: return {15'd0, m_mask, 15'd0, m_done_st};
      8'h18: return {29'd0, m_err};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_wcount = '0; m_io_mem = 0; m_done_st = 0; m_mask = 0; m_done_phase = 0;
    m_io_addr = '0; m_mem_addr = '0; m_xfer = '0; m_rdata = '0; m_err = '0; m_run_left = 0;
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit       idle, start, done_set, done_clr;
    int       n;
    bit [2:0] eset, eclr;
    idle     = (m_run_left == 0) && !m_done_phase;
    start    = wr && m_mapped(a) && a[7:0] == 8'h00 && d[0];
    n        = int'(d[16:1]);
    done_set = 0; done_clr = 0; eset = '0; eclr = '0;
    if (rd) m_rdata = m_read(a);
    if (ERR_EN) begin
      eset[0] = (wr || rd) && !m_mapped(a);
      eset[1] = start && n == 0;
      eset[2] = start && !idle;
    end
    if (m_run_left > 0) begin
      m_run_left--;
      if (m_run_left == 0) m_done_phase = 1;
    end else if (m_done_phase) begin
      m_done_phase = 0;
      m_xfer++;
      done_set = 1;
    end else if (start && n != 0) begin
      m_run_left = n;
    end
    if (wr && m_mapped(a)) begin
      case (a[7:0])
        8'h00: begin m_wcount = d[16:1]; m_io_mem = d[17]; end
        8'h04: m_io_addr = d;
        8'h08: m_mem_addr = d;
        8'h14: begin m_mask = d[16]; done_clr = d[0]; end
        8'h18: eclr = d[2:0];
        default: ;
      endcase
    end
    m_done_st = (m_done_st && !done_clr) || done_set;
    m_err     = (m_err & ~eclr) | eset;
  endtask

  task automatic cycle(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    wr_en = wr; rd_en = rd; addr = a; wdata = d;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(wr, rd, a, d);
    #1;
    check_val("busy", {31'd0, busy}, {31'd0, m_run_left > 0});
    check_val("irq", {31'd0, irq}, {31'd0, m_done_st & m_mask});
    check_val("rdata", rdata, m_rdata);
    wr_en = 0; rd_en = 0;
  endtask

  task automatic idle_cyc();
    cycle(0, 0, 32'd0, 32'd0);
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    cycle(1, 0, a, d);
  endtask

  task automatic reg_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    cycle(0, 1, a, 32'd0);
    check_val(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nbusy;
    logic [31:0] addrs [12];
    logic [31:0] a, d;
    int          op;
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18,
              32'h1C, 32'h20, 32'h102, 32'h100, 32'h8000_0004};
    wr_en = 0; rd_en = 0; addr = '0; wdata = '0;
    model_reset();

    // reset, then every mapped address reads zero
    rst_n = 0;
    idle_cyc(); idle_cyc();
    rst_n = 1;
    for (int i = 0; i < 7; i++) reg_rd("reset_read", addrs[i], 32'd0);

    // RW register, RO write ignored, same-address read+write returns old value
    reg_wr(32'h04, 32'hDEAD_BEEF);
    reg_rd("io_addr", 32'h04, 32'hDEAD_BEEF);
    reg_wr(32'h0C, 32'hFFFF_FFFF);
    reg_rd("status_ro", 32'h0C, 32'd0);
    cycle(1, 1, 32'h04, 32'h1234_5678);
    check_val("rd_wr_old", rdata, 32'hDEAD_BEEF);
    reg_rd("rd_wr_new", 32'h04, 32'h1234_5678);

    // four-word transfer with interrupt enabled
    reg_wr(32'h14, 32'h0001_0000);
    reg_wr(32'h00, 32'h0000_0009);
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 10; i++) begin idle_cyc(); nbusy += busy ? 1 : 0; end
    check_val("busy_len4", nbusy, 4);
    reg_rd("status_done", 32'h0C, 32'h0000_0002);
    reg_rd("xfer_cnt1", 32'h10, 32'd1);
    reg_rd("ctrl_rb", 32'h00, 32'h0000_0008);
    check_val("irq_set", {31'd0, irq}, 32'd1);
    reg_wr(32'h14, 32'h0001_0001);
    check_val("irq_clr", {31'd0, irq}, 32'd0);

    // W1C of DONE_ST landing on the completion edge: set wins
    reg_wr(32'h00, 32'h0000_0005);
    for (int i = 0; i < 10 && !m_done_phase; i++) idle_cyc();
    reg_wr(32'h14, 32'h0001_0001);
    check_val("done_set_prio", {31'd0, irq}, 32'd1);
    reg_wr(32'h14, 32'h0001_0001);
    reg_rd("xfer_cnt2", 32'h10, 32'd2);

    // zero-count start, then a second start while running
    reg_wr(32'h00, 32'h0000_0001);
    check_val("zero_start_busy", {31'd0, busy}, 32'd0);
    reg_rd("err_zero", 32'h18, ERR_EN ? 32'h2 : 32'h0);
    reg_wr(32'h00, 32'h0000_0007);
    nbusy = busy ? 1 : 0;
    reg_wr(32'h00, 32'h0000_0009);
    nbusy += busy ? 1 : 0;
    for (int i = 0; i < 10; i++) begin idle_cyc(); nbusy += busy ? 1 : 0; end
    check_val("busy_len3", nbusy, 3);
    reg_rd("err_busy", 32'h18, ERR_EN ? 32'h6 : 32'h0);

    // illegal addresses
    reg_wr(32'h18, 32'h7);
    reg_rd("unmapped_1c", 32'h1C, 32'd0);
    reg_rd("unaligned_102", 32'h102, 32'd0);
    reg_rd("err_addr", 32'h18, ERR_EN ? 32'h1 : 32'h0);
    reg_wr(32'h18, 32'h1);
    reg_rd("err_w1c", 32'h18, 32'd0);

    // reset in the middle of a transfer
    reg_wr(32'h14, 32'h0001_0001);
    reg_wr(32'h00, 32'h0000_0011);
    idle_cyc(); idle_cyc(); idle_cyc();
    rst_n = 0;
    idle_cyc();
    rst_n = 1;
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 12; i++) idle_cyc();
    reg_rd("abort_xfer", 32'h10, 32'd0);
    reg_rd("abort_status", 32'h0C, 32'd0);
    check_val("abort_irq", {31'd0, irq}, 32'd0);

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 99);
      a  = addrs[$urandom_range(0, 11)];
      d  = $urandom;
      if (a == 32'h00) d[16:1] = 16'($urandom_range(0, 5));
      if (op < 2) begin
        rst_n = 0; idle_cyc(); rst_n = 1;
      end else if (op < 30) idle_cyc();
      else if (op < 60) cycle(0, 1, a, 32'd0);
      else if (op < 90) cycle(1, 0, a, d);
      else cycle(1, 1, a, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dma_reg_resp.md
DMA_REG_RESP -- requirements
Module: dma_reg_resp

Interface
REQ-001 SHALL clock on clk (input, 1): all state updates on posedge clk.
REQ-002 SHALL reset on rst_n (input, 1): synchronous, active-low.
REQ-003 SHALL accept wr_en (input, 1): write strobe from the initiator, sampled at posedge clk.
REQ-004 SHALL accept rd_en (input, 1): read strobe, sampled at posedge clk.
REQ-005 SHALL accept addr (input, 32): byte address of the register.
REQ-006 SHALL accept wdata (input, 32): write data.
REQ-007 SHALL drive rdata (output, 32): registered read data.
REQ-008 SHALL drive irq (output, 1): level interrupt, equal to INTR.DONE_ST & INTR.DONE_MASK.
REQ-009 SHALL drive busy (output, 1): high while the engine is in state RUN.

Function
REQ-010 SHALL decode these registers, all others unmapped:
- 0x00 CTRL: [0] START (write-1, reads 0), [16:1] W_COUNT RW, [17] IO_MEM RW.
- 0x04 IO_ADDR: RW.
- 0x08 MEM_ADDR: RW.
- 0x0C STATUS: RO; [0] BUSY, [1] DONE_ST, [31:16] remaining count.
- 0x10 XFER_CNT: RO; completed transfers, 32-bit, wraps to 0.
- 0x14 INTR: [0] DONE_ST W1C, [16] DONE_MASK RW.
- 0x18 ERR: [0] illegal address, [1] zero-count start, [2] start while busy; all sticky, W1C.
REQ-011 SHALL treat as unmapped any address with addr[31:8] != 0, with addr[1:0] != 0, or not in the map; unmapped reads return 0 and unmapped writes are ignored.
REQ-012 SHALL register rdata one cycle after the rd_en sample edge, and hold rdata unchanged in cycles without rd_en.
REQ-013 SHALL, when wr_en and rd_en are both high on the same address, return the pre-write value on rdata and commit the write.
REQ-014 SHALL implement an engine FSM with states IDLE, RUN and DONE.
- IDLE->RUN: CTRL write with START=1 and W_COUNT != 0; remaining count loads W_COUNT from the same write.
- RUN: remaining count decrements by 1 each cycle; RUN->DONE on the edge where remaining count goes 1->0.
- DONE->IDLE: after exactly one cycle; on that edge DONE_ST is set and XFER_CNT increments.
REQ-015 SHALL make a transfer of W_COUNT=N occupy N RUN cycles plus 1 DONE cycle, with busy high for exactly N cycles.
REQ-016 SHALL ignore a START=1 write with W_COUNT=0 and set ERR[1]; the other CTRL fields still update.
REQ-017 SHALL ignore a START=1 write in RUN or DONE and set ERR[2]; the other CTRL fields update, and the running transfer is unaffected because its count was latched at start.
REQ-018 SHALL give the hardware set priority when a W1C clear of DONE_ST and the DONE->IDLE set occur on the same edge (bit ends 1).
REQ-019 SHALL give hardware set priority over W1C clear on the same edge for every ERR bit.

Reset
REQ-020 SHALL, with rst_n low at posedge clk, force the FSM to IDLE and clear all registers, rdata, irq and busy to 0, including during RUN; no completion event is generated for an aborted transfer.

Configuration
REQ-021 SHALL, with DMA_REG_ERR_EN defined, implement the ERR register and its detection as specified in REQ-010, REQ-016, REQ-017 and REQ-019.
REQ-022 SHALL, without DMA_REG_ERR_EN, treat 0x18 as unmapped, set no error bits, and still ignore illegal starts.

Structure
REQ-023 SHALL place the following in package dma_reg_pkg: register address localparams, field bit positions, the count width (16), and the engine state enum.
REQ-024 SHALL put the FSM and the remaining/XFER_CNT counters in sub-module dma_xfer_engine; register decode and rdata stay in dma_reg_resp.

Verification
REQ-025 SHALL cover: reset, then read every mapped address -> rdata 0 one cycle after each rd_en.
REQ-026 SHALL cover: write 0x04=0xDEAD_BEEF, then read 0x04 -> 0xDEAD_BEEF; write 0x0C=0xFFFF_FFFF -> STATUS unchanged.
REQ-027 SHALL cover: write INTR=0x0001_0000, then CTRL=0x0000_0009 (W_COUNT=4, START) -> busy high 4 cycles, DONE_ST=1, XFER_CNT=1, irq=1; write INTR=0x0001_0001 -> irq=0.
REQ-028 SHALL cover: CTRL START with W_COUNT=0 -> busy stays 0 and ERR=0x2; repeat START during RUN -> ERR=0x6 and busy length unchanged.
REQ-029 SHALL cover: read 0x1C and 0x102 -> rdata 0, ERR[0]=1; write 0x18=0x1 -> ERR[0]=0.
REQ-030 SHALL cover: assert rst_n=0 for 1 cycle mid-RUN -> busy 0 the next cycle, XFER_CNT stays 0, irq 0.
